// File: rtl/word_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : word_tx_serializer
//  Description : Splits an NBITS-wide word from the debug controller into
//                NBYTES bytes and hands them one at a time to a UART
//                transmitter, using a start-pulse / done-tick handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1           rising-edge clock
//    reset         in   1           asynchronous active-high reset
//    i_start       in   1           word-send request, held until o_done
//    i_word        in   NBITS       word to send, sampled on acceptance only
//    i_byte_done   in   1           UART tick: current byte finished
//    o_byte        out  BYTE_WIDTH  byte presented to the UART (registered)
//    o_byte_start  out  1           one-cycle send request per byte
//    o_done        out  1           one-cycle pulse after the last byte
//    o_busy        out  1           high while a word is in flight
// ============================================================================
module word_tx_serializer #(
    parameter int NBITS      = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [NBITS-1:0]      i_word,
    input  logic                  i_byte_done,
    output logic [BYTE_WIDTH-1:0] o_byte,
    output logic                  o_byte_start,
    output logic                  o_done,
    output logic                  o_busy
);

    localparam int NBYTES = NBITS / BYTE_WIDTH;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_FINISH = 2'd2,
        ST_REARM  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NBITS-1:0]        shreg_q, shreg_d;
    logic [BYTE_WIDTH-1:0]   byte_q, byte_d;
    logic                    byte_start_q, byte_start_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    // Byte-order selection. The shift register always keeps the byte that
    // is currently on o_byte at the "outgoing" end; advancing shifts it away
    // and the new outgoing byte is read from the shifted value.
    logic [BYTE_WIDTH-1:0]   w_first_byte;
    logic [NBITS-1:0]        w_shifted;
    logic [BYTE_WIDTH-1:0]   w_next_byte;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_first_byte = i_word[NBITS-1 -: BYTE_WIDTH];
            assign w_shifted    = shreg_q << BYTE_WIDTH;
            assign w_next_byte  = w_shifted[NBITS-1 -: BYTE_WIDTH];
        end else begin : g_lsb_first
            assign w_first_byte = i_word[BYTE_WIDTH-1:0];
            assign w_shifted    = shreg_q >> BYTE_WIDTH;
            assign w_next_byte  = w_shifted[BYTE_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            byte_q       <= '0;
            byte_start_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            byte_q       <= byte_d;
            byte_start_q <= byte_start_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        byte_d       = byte_q;
        byte_start_d = 1'b0;
        done_d       = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    shreg_d      = i_word;
                    cnt_d        = '0;
                    byte_d       = w_first_byte;
                    byte_start_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // A done tick coinciding with our own start pulse cannot
                // belong to the byte just requested, so it is dropped.
                if (i_byte_done && !byte_start_q) begin
                    if (cnt_q != C_LAST_IDX) begin
                        cnt_d        = cnt_q + C_CNT_ONE;
                        shreg_d      = w_shifted;
                        byte_d       = w_next_byte;
                        byte_start_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_FINISH;
                    end
                end
            end

            ST_FINISH: begin
                state_d = ST_REARM;
            end

            ST_REARM: begin
                // Upstream holds i_start until it sees o_done; wait for it to
                // drop so the same request is not serviced twice.
                if (!i_start) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_byte       = byte_q;
    assign o_byte_start = byte_start_q;
    assign o_done       = done_q;
    assign o_busy       = busy_q;

endmodule
`default_nettype wire
